// File: rtl/inv_mixcolumn_iter_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES helpers for the decrypt-side column engines.
//   xtime    : multiply a GF(2^8) element by x (0x02), reducing mod 0x11B
//   gmul_inv : product of a byte with one of the InvMixColumns coefficients
//              (09, 0b, 0d, 0e), built only from chained xtime
//   NB, WORD_W, STATE_W : column count and widths of the AES state
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int NB      = 4;
  localparam int WORD_W  = 32;
  localparam int STATE_W = NB * WORD_W;

  typedef enum logic [1:0] {
    COEF_09,
    COEF_0B,
    COEF_0D,
    COEF_0E
  } coef_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } imc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
  endfunction

  // a*2, a*4, a*8 are formed once and XOR-combined per coefficient.
  function automatic logic [7:0] gmul_inv(input logic [7:0] a, input coef_e sel);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    logic [7:0] r;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (sel)
      COEF_09: r = x8 ^ a;
      COEF_0B: r = x8 ^ x2 ^ a;
      COEF_0D: r = x8 ^ x4 ^ a;
      default: r = x8 ^ x4 ^ x2;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inv_mixcolumn_iter_if.sv
// ---------------------------------------------------------------------------
// inv_mixcolumn_iter_if
// Valid/ready bundle for the iterative InvMixColumns engine.
//   in_valid_i / in_ready_o / state_i    : input state handshake
//   out_valid_o / out_ready_i / state_o  : result handshake
//   busy_o                               : engine holds a state
// master = the side that feeds states and consumes results.
// slave  = the engine itself.
// ---------------------------------------------------------------------------
interface inv_mixcolumn_iter_if;
  import aes_pkg::*;

  logic               in_valid_i;
  logic               in_ready_o;
  logic [STATE_W-1:0] state_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [STATE_W-1:0] state_o;
  logic               busy_o;

  modport master (
    output in_valid_i,
    output state_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  state_o,
    input  busy_o
  );

  modport slave (
    input  in_valid_i,
    input  state_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output state_o,
    output busy_o
  );

endinterface

// File: rtl/inv_mixcolumn_word.sv
// ---------------------------------------------------------------------------
// inv_mixcolumn_word
// Purely combinational InvMixColumns of a single 32-bit column.
//   word_i : column, row r in bits [8r+7:8r]
//   word_o : transformed column, same packing
// ---------------------------------------------------------------------------
module inv_mixcolumn_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] word_o
);

  logic [7:0] s0, s1, s2, s3;

  assign s0 = word_i[7:0];
  assign s1 = word_i[15:8];
  assign s2 = word_i[23:16];
  assign s3 = word_i[31:24];

  assign word_o[7:0]   = gmul_inv(s0, COEF_0E) ^ gmul_inv(s1, COEF_0B) ^
                         gmul_inv(s2, COEF_0D) ^ gmul_inv(s3, COEF_09);
  assign word_o[15:8]  = gmul_inv(s0, COEF_09) ^ gmul_inv(s1, COEF_0E) ^
                         gmul_inv(s2, COEF_0B) ^ gmul_inv(s3, COEF_0D);
  assign word_o[23:16] = gmul_inv(s0, COEF_0D) ^ gmul_inv(s1, COEF_09) ^
                         gmul_inv(s2, COEF_0E) ^ gmul_inv(s3, COEF_0B);
  assign word_o[31:24] = gmul_inv(s0, COEF_0B) ^ gmul_inv(s1, COEF_0D) ^
                         gmul_inv(s2, COEF_09) ^ gmul_inv(s3, COEF_0E);

endmodule

// File: rtl/inv_mixcolumn_iter.sv
// ---------------------------------------------------------------------------
// inv_mixcolumn_iter
// Iterative AES InvMixColumns: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock and presents the result until taken.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of inv_mixcolumn_iter_if
//              (in_valid_i/in_ready_o/state_i, out_valid_o/out_ready_i/
//               state_o, busy_o)
// Parameter COLS_PER_CYCLE : 1, 2 or 4 columns per clock.
// ---------------------------------------------------------------------------
module inv_mixcolumn_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  inv_mixcolumn_iter_if.slave  bus
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
    $error("inv_mixcolumn_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // The 2-bit step wraps to 0 for 4 columns/cycle, which is exactly right.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(NB - COLS_PER_CYCLE);

  imc_state_e         state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [STATE_W-1:0] in_q, in_d;
  logic [STATE_W-1:0] res_q, res_d;

  logic [1:0]        col_idx  [COLS_PER_CYCLE];
  logic [WORD_W-1:0] word_in  [COLS_PER_CYCLE];
  logic [WORD_W-1:0] word_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = cnt_q + 2'(g);
    assign word_in[g] = in_q[{col_idx[g], 5'b0} +: WORD_W];

    inv_mixcolumn_word u_word (
      .word_i (word_in[g]),
      .word_o (word_out[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid_i)     state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == CNT_LAST)  state_d = ST_DONE;
      ST_DONE: if (bus.out_ready_i)    state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready_o  = 1'b0;
    bus.out_valid_o = 1'b0;
    bus.busy_o      = 1'b0;
    case (state_q)
      ST_IDLE: bus.in_ready_o = 1'b1;
      ST_BUSY: bus.busy_o     = 1'b1;
      ST_DONE: begin
        bus.out_valid_o = 1'b1;
        bus.busy_o      = 1'b1;
      end
      default: bus.in_ready_o = 1'b0;
    endcase
  end

  // Datapath: the input copy is frozen for the whole pass so later columns
  // read original bytes; the result register only changes in BUSY.
  always_comb begin
    cnt_d = cnt_q;
    in_d  = in_q;
    res_d = res_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid_i) begin
          in_d  = bus.state_i;
          cnt_d = 2'd0;
        end
      end
      ST_BUSY: begin
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
          res_d[{col_idx[i], 5'b0} +: WORD_W] = word_out[i];
        end
        cnt_d = cnt_q + CNT_STEP;
      end
      ST_DONE: begin
        if (bus.out_ready_i) cnt_d = 2'd0;
      end
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
      in_q  <= '0;
      res_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      in_q  <= in_d;
      res_q <= res_d;
    end
  end

  assign bus.state_o = res_q;

endmodule

// File: tb/tb_inv_mixcolumn_iter.sv
// ---------------------------------------------------------------------------
// tb_inv_mixcolumn_iter
// Directed bench for inv_mixcolumn_iter. Three engines (1, 2 and 4 columns
// per cycle) share the state input; the 1-column engine has its own
// valid/ready so it can be exercised alone.
// ---------------------------------------------------------------------------
module tb_inv_mixcolumn_iter;
  import aes_pkg::*;

  localparam logic [127:0] SAME_IN   = {4{32'hbca14d8e}};
  localparam logic [127:0] SAME_OUT  = {4{32'h455313db}};
  localparam logic [127:0] MIXED_IN  = {32'hc6c6c6c6, 32'hd6d7d5d5, 32'h9d58dc9f, 32'hbca14d8e};
  localparam logic [127:0] MIXED_OUT = {32'hc6c6c6c6, 32'hd5d4d4d4, 32'h5c220af2, 32'h455313db};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] stateIn = '0;
  logic         inValid1 = 1'b0;
  logic         outReady1 = 1'b0;
  logic         inValidAll = 1'b0;
  logic         outReadyAll = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inv_mixcolumn_iter_if bus1 ();
  inv_mixcolumn_iter_if bus2 ();
  inv_mixcolumn_iter_if bus4 ();

  assign bus1.in_valid_i  = inValid1;
  assign bus1.out_ready_i = outReady1;
  assign bus1.state_i     = stateIn;
  assign bus2.in_valid_i  = inValidAll;
  assign bus2.out_ready_i = outReadyAll;
  assign bus2.state_i     = stateIn;
  assign bus4.in_valid_i  = inValidAll;
  assign bus4.out_ready_i = outReadyAll;
  assign bus4.state_i     = stateIn;

  inv_mixcolumn_iter #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  inv_mixcolumn_iter #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  inv_mixcolumn_iter #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // Forward MixColumns reference, used to build inputs whose inverse is known.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [127:0] fwdMix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] b0, b1, b2, b3;
    for (int c = 0; c < 4; c++) begin
      b0 = s[32*c +: 8];
      b1 = s[32*c+8 +: 8];
      b2 = s[32*c+16 +: 8];
      b3 = s[32*c+24 +: 8];
      r[32*c +: 8]    = xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
      r[32*c+8 +: 8]  = b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3;
      r[32*c+16 +: 8] = b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3;
      r[32*c+24 +: 8] = xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3);
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle valid pulse; every targeted engine is expected to be in IDLE.
  task automatic applyStimulus(input logic [127:0] st, input bit all);
    stateIn    = st;
    inValid1   = 1'b1;
    inValidAll = all;
    tick();
    inValid1   = 1'b0;
    inValidAll = 1'b0;
  endtask

  task automatic measureLatency(input bit all, output int lat1, output int lat2, output int lat4);
    int cyc;
    cyc  = 0;
    lat1 = -1;
    lat2 = -1;
    lat4 = -1;
    while ((lat1 < 0 || (all && (lat2 < 0 || lat4 < 0))) && cyc < 12) begin
      tick();
      cyc++;
      if (bus1.out_valid_o && lat1 < 0) lat1 = cyc;
      if (bus2.out_valid_o && lat2 < 0) lat2 = cyc;
      if (bus4.out_valid_o && lat4 < 0) lat4 = cyc;
    end
  endtask

  task automatic releaseResults(input bit all);
    outReady1   = 1'b1;
    outReadyAll = all;
    tick();
    outReady1   = 1'b0;
    outReadyAll = 1'b0;
    checkOutput("release_idle1", 128'({bus1.in_ready_o, bus1.out_valid_o, bus1.busy_o}), 128'b100);
    if (all) begin
      checkOutput("release_idle2", 128'({bus2.in_ready_o, bus2.out_valid_o, bus2.busy_o}), 128'b100);
      checkOutput("release_idle4", 128'({bus4.in_ready_o, bus4.out_valid_o, bus4.busy_o}), 128'b100);
    end
  endtask

  initial begin
    int l1, l2, l4;
    logic [127:0] held;
    logic [127:0] x;
    logic [127:0] got;
    bit done;
    bit acc;
    bit dn;
    int lastAcc;
    int nAcc;
    logic [127:0] expQ[$];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_flags1", 128'({bus1.in_ready_o, bus1.out_valid_o, bus1.busy_o}), 128'b100);
    checkOutput("reset_state1", bus1.state_o, 128'h0);
    checkOutput("reset_flags4", 128'({bus4.in_ready_o, bus4.out_valid_o, bus4.busy_o}), 128'b100);
    rst = 1'b0;
    tick();

    // Identical columns, all engines
    applyStimulus(SAME_IN, 1'b1);
    measureLatency(1'b1, l1, l2, l4);
    checkOutput("same_lat1", 128'(l1), 128'd4);
    checkOutput("same_lat2", 128'(l2), 128'd2);
    checkOutput("same_lat4", 128'(l4), 128'd1);
    checkOutput("same_out1", bus1.state_o, SAME_OUT);
    checkOutput("same_out2", bus2.state_o, SAME_OUT);
    checkOutput("same_out4", bus4.state_o, SAME_OUT);
    releaseResults(1'b1);

    // Mixed columns, all engines
    applyStimulus(MIXED_IN, 1'b1);
    measureLatency(1'b1, l1, l2, l4);
    checkOutput("mixed_lat1", 128'(l1), 128'd4);
    checkOutput("mixed_lat2", 128'(l2), 128'd2);
    checkOutput("mixed_lat4", 128'(l4), 128'd1);
    checkOutput("mixed_out1", bus1.state_o, MIXED_OUT);
    checkOutput("mixed_out2", bus2.state_o, MIXED_OUT);
    checkOutput("mixed_out4", bus4.state_o, MIXED_OUT);
    releaseResults(1'b1);

    // Backpressure in DONE with a competing input request
    applyStimulus(MIXED_IN, 1'b0);
    measureLatency(1'b0, l1, l2, l4);
    checkOutput("bp_lat1", 128'(l1), 128'd4);
    held     = bus1.state_o;
    stateIn  = SAME_IN;
    inValid1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp_flags", 128'({bus1.in_ready_o, bus1.out_valid_o, bus1.busy_o}), 128'b011);
      checkOutput("bp_state", bus1.state_o, MIXED_OUT);
    end
    inValid1 = 1'b0;
    releaseResults(1'b0);
    checkOutput("bp_state_after", bus1.state_o, held);

    // Reset in the middle of BUSY, after two columns are written
    applyStimulus(SAME_IN, 1'b0);
    tick();
    tick();
    checkOutput("mid_busy", 128'(bus1.busy_o), 128'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_flags", 128'({bus1.in_ready_o, bus1.out_valid_o, bus1.busy_o}), 128'b100);
    checkOutput("midrst_state", bus1.state_o, 128'h0);
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(MIXED_IN, 1'b0);
    measureLatency(1'b0, l1, l2, l4);
    checkOutput("postrst_lat1", 128'(l1), 128'd4);
    checkOutput("postrst_out1", bus1.state_o, MIXED_OUT);
    releaseResults(1'b0);

    // Round trip with random stalls on both sides
    for (int n = 0; n < 1000; n++) begin
      x       = rand128();
      stateIn = fwdMix(x);
      repeat ($urandom_range(0, 3)) tick();
      inValid1 = 1'b1;
      done = 1'b0;
      for (int w = 0; w < 50 && !done; w++) begin
        acc = bus1.in_ready_o;
        tick();
        done = acc;
      end
      inValid1 = 1'b0;
      if (!done) begin
        checks++;
        failures++;
        $display("[TB] FAIL rt_accept: no acceptance within 50 cycles, item %0d", n);
      end else begin
        done = 1'b0;
        got  = '0;
        for (int w = 0; w < 100 && !done; w++) begin
          outReady1 = 1'($urandom_range(0, 1));
          if (bus1.out_valid_o && outReady1) begin
            got  = bus1.state_o;
            done = 1'b1;
          end
          tick();
        end
        outReady1 = 1'b0;
        if (done) begin
          checkOutput("roundtrip", got, x);
        end else begin
          checks++;
          failures++;
          $display("[TB] FAIL rt_result: no result within 100 cycles, item %0d", n);
        end
      end
    end

    // Back-to-back: valid and ready held high
    lastAcc   = -1;
    nAcc      = 0;
    x         = rand128();
    stateIn   = fwdMix(x);
    inValid1  = 1'b1;
    outReady1 = 1'b1;
    for (int cyc = 0; cyc < 86; cyc++) begin
      if (cyc == 66) inValid1 = 1'b0;
      @(negedge clk);
      acc = bus1.in_ready_o && inValid1;
      dn  = bus1.out_valid_o && outReady1;
      got = bus1.state_o;
      @(posedge clk);
      #1;
      if (dn) begin
        if (expQ.size() > 0) begin
          checkOutput("b2b_data", got, expQ.pop_front());
        end else begin
          checks++;
          failures++;
          $display("[TB] FAIL b2b_extra: unexpected result %h", got);
        end
      end
      if (acc) begin
        expQ.push_back(x);
        if (lastAcc >= 0) checkOutput("b2b_gap", 128'(cyc - lastAcc), 128'd6);
        lastAcc = cyc;
        nAcc++;
        x       = rand128();
        stateIn = fwdMix(x);
      end
    end
    outReady1 = 1'b0;
    checkOutput("b2b_count", 128'(nAcc), 128'd11);
    checkOutput("b2b_drained", 128'(expQ.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
